// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer stage encoding and stage helpers
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } stage_t;

    // Stages that consume a cycle of useful work for the cycle counter
    function automatic logic stage_active(input stage_t s);
        return !(s == ST_IDLE || s == ST_HALT || s == ST_FAULT);
    endfunction

    // Stages that wait on a memory handshake and are covered by the watchdog
    function automatic logic stage_waits(input stage_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/seq_wdog.sv
// rtl/seq_wdog.sv - memory wait watchdog, flags the cycle the wait count reaches its limit
module seq_wdog #(
    parameter int LIMIT = 15
) (
    input  logic r_clk,
    input  logic r_rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // Count not-ready cycles; a clear (stage change) always restarts from zero
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + W'(1);
        end
    end

    // Expired when this cycle's not-ready count would reach LIMIT
    assign expired = count_en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - multi-cycle CPU control sequencer with memory wait watchdog
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_wb,
    input  logic             dec_halt,
    output stage_t           stage,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             retire,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    stage_t state;
    stage_t next_state;
    logic   ready_now;
    logic   wd_clear;
    logic   wd_count;
    logic   wd_expired;

    assign ready_now = (state == ST_FETCH) ? imem_ready : dmem_ready;
    assign wd_count  = stage_waits(state) && !ready_now;
    assign wd_clear  = (next_state != state);
    assign stage     = state;

    seq_wdog #(
        .LIMIT    (MEM_TIMEOUT)
    ) u_wdog (
        .r_clk    (r_clk),
        .r_rst_n  (r_rst_n),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    // Stage register
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next stage; a ready handshake beats a watchdog expiry in the same cycle
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready)      next_state = ST_DECODE;
                else if (wd_expired) next_state = ST_FAULT;
            end
            ST_DECODE: next_state = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   next_state = (dec_load || dec_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ready)      next_state = dec_store ? ST_FETCH : ST_WB;
                else if (wd_expired) next_state = ST_FAULT;
            end
            ST_WB:     next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            ST_FAULT:  next_state = ST_FAULT;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath controls from stage, with ir_we/retire as handshake-qualified pulses
    always_comb begin
        imem_req = (state == ST_FETCH);
        ir_we    = (state == ST_FETCH) && imem_ready;
        dmem_req = (state == ST_MEM);
        dmem_we  = (state == ST_MEM) && dec_store;
        rf_we    = (state == ST_WB) && dec_wb;
        pc_we    = (state == ST_WB) || ((state == ST_MEM) && dmem_ready && dec_store);
        retire   = pc_we;
        halted   = (state == ST_HALT);
        fault    = (state == ST_FAULT);
    end

    // Performance counters, frozen outside the working stages
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (stage_active(state)) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)              instret   <= instret + CNT_W'(1);
        end
    end

endmodule
